// File: rtl/div_iter_seq_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e : FSM state codes (2-bit)
//   DIV_START / DIV_STOP               : start_i levels
//   DIV_RESULT_READY / DIV_RESULT_NOT_READY : ready_o levels
package div_iter_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BYZERO  = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_seq_clz.sv
// div_clz: combinational leading-zero counter, WIDTH-parameterised.
// Only built with DIV_EARLY_TERM_EN defined.
//   data_i : value to scan
//   clz_o  : number of leading zeros (WIDTH when data_i == 0)
`ifdef DIV_EARLY_TERM_EN
module div_clz #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] clz_o
);

    // Scan upward; the highest set bit is the last one to write clz_o.
    always_comb begin
        clz_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) clz_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule
`endif

// File: rtl/div_iter_seq.sv
// div_iter_seq: multi-cycle restoring divider, signed/unsigned, one quotient
// bit per cycle. Result is {remainder, quotient}.
// Optional build macro: DIV_EARLY_TERM_EN -- skips the leading zeros of |a|,
// shortening latency; results are identical.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         request, held by EX until ready_o
//   annul_i         abort (flush) in ON/BYZERO, blocks a start in IDLE
//   signed_i        1 = signed divide
//   opdata1_i/2_i   dividend / divisor, sampled in IDLE on accept
//   result_o        {remainder, quotient}
//   ready_o         result valid, held while start_i stays high
//   busy_o          FSM not idle
//   div_zero_o      last accepted divisor was zero
//   stallreq_o      start_i & ~ready_o
module div_iter_seq
    import div_iter_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o,
    output logic               stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e state_q, state_d;

    logic [WIDTH-1:0] rem_q, quot_q, divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_a_q, sign_b_q;

    // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign sign_a = signed_i & opdata1_i[WIDTH-1];
    assign sign_b = signed_i & opdata2_i[WIDTH-1];
    assign a_abs  = sign_a ? (~opdata1_i + 1'b1) : opdata1_i;
    assign b_abs  = sign_b ? (~opdata2_i + 1'b1) : opdata2_i;

    logic             accept;
    assign accept = (state_q == DIV_FREE) && (start_i == DIV_START) && !annul_i;

    // Initial quotient-register contents and step count for a new operation.
    logic [WIDTH-1:0] start_quot;
    logic [CNT_W-1:0] start_cnt;
    logic             a_zero;
`ifdef DIV_EARLY_TERM_EN
    logic [CNT_W-1:0] a_clz;
    div_clz #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_clz (
        .data_i (a_abs),
        .clz_o  (a_clz)
    );
    // Leading zeros of the dividend would only shift zeros into the
    // remainder, so pre-shift them out and run fewer steps.
    assign a_zero     = (a_abs == '0);
    assign start_quot = a_abs << a_clz;
    assign start_cnt  = CNT_W'(WIDTH) - a_clz;
`else
    assign a_zero     = 1'b0;
    assign start_quot = a_abs;
    assign start_cnt  = CNT_W'(WIDTH);
`endif

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
    // The partial remainder needs WIDTH+1 bits since it can reach 2*|b|-1.
    logic [WIDTH:0]   partial, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quot_nx;
    assign partial = {rem_q, quot_q[WIDTH-1]};
    assign diff    = partial - {1'b0, divisor_q};
    assign ge      = ~diff[WIDTH];
    assign rem_nx  = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quot_nx = {quot_q[WIDTH-2:0], ge};

    // Sign fix: quotient sign is the XOR of the operand signs, remainder
    // follows the dividend. MIN/-1 wraps back to MIN.
    logic [WIDTH-1:0] quot_fix, rem_fix;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? (~quot_q + 1'b1) : quot_q;
    assign rem_fix  = sign_a_q ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= DIV_FREE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (accept) begin
                    if (opdata2_i == '0) state_d = DIV_BYZERO;
                    else if (a_zero)     state_d = DIV_END;
                    else                 state_d = DIV_ON;
                end
            end
            DIV_BYZERO: state_d = annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul_i)                   state_d = DIV_FREE;
                else if (cnt_q == CNT_W'(1))   state_d = DIV_END;
            end
            DIV_END: if (start_i == DIV_STOP) state_d = DIV_FREE;
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_NOT_READY;
            div_zero_o <= 1'b0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    ready_o <= DIV_RESULT_NOT_READY;
                    if (accept && opdata2_i != '0) begin
                        div_zero_o <= 1'b0;
                        rem_q      <= '0;
                        quot_q     <= start_quot;
                        divisor_q  <= b_abs;
                        sign_a_q   <= sign_a;
                        sign_b_q   <= sign_b;
                        cnt_q      <= start_cnt;
                    end
                end
                // Zero-divisor result is final here, so ready rises on entry
                // to END rather than one cycle later.
                DIV_BYZERO: begin
                    if (!annul_i) begin
                        result_o   <= '0;
                        div_zero_o <= 1'b1;
                        ready_o    <= DIV_RESULT_READY;
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        rem_q  <= rem_nx;
                        quot_q <= quot_nx;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                DIV_END: begin
                    // ready_o low on the first END cycle marks the single
                    // sign-fix/result write.
                    if (ready_o == DIV_RESULT_NOT_READY) result_o <= {rem_fix, quot_fix};
                    ready_o <= (start_i == DIV_START) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != DIV_FREE);
    assign stallreq_o = start_i & ~ready_o;

endmodule

// File: tb/tb_div_iter_seq.sv
// Directed self-checking bench for div_iter_seq (WIDTH=32).
module tb_div_iter_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, annul_i, signed_i;
    logic [W-1:0]  opdata1_i, opdata2_i;
    logic [2*W-1:0] result_o;
    logic          ready_o, busy_o, div_zero_o, stallreq_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_iter_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .div_zero_o (div_zero_o),
        .stallreq_o (stallreq_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected cycle at which ready_o first shows, counting the start cycle as 0.
    function automatic int exp_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] aa;
        int z;
        aa = (s && a[W-1]) ? (~a + 1'b1) : a;
        z  = 0;
        if (b == '0) return 2;
`ifdef DIV_EARLY_TERM_EN
        if (aa == '0) return 2;
        for (int i = W - 1; i >= 0; i--) begin
            if (aa[i]) break;
            z++;
        end
`endif
        return W - z + 2;
    endfunction

    task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [63:0] exp_res,
                           input logic exp_zero);
        int cyc;
        logic stall_ok;
        @(negedge clk);
        start_i = 1'b1; signed_i = s; opdata1_i = a; opdata2_i = b;
        #1;
        stall_ok = stallreq_o;
        cyc = 0;
        while (!ready_o && cyc < 100) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (!ready_o) stall_ok = stall_ok & stallreq_o;
        end
        chk({tag, ".lat"},    64'(cyc), 64'(exp_lat(s, a, b)));
        chk({tag, ".res"},    result_o, exp_res);
        chk({tag, ".zero"},   64'(div_zero_o), 64'(exp_zero));
        chk({tag, ".stall"},  {63'd0, stall_ok}, 64'd1);
        chk({tag, ".stall_rdy"}, 64'(stallreq_o), 64'd0);
        // Operands change after acceptance; they must be ignored.
        opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0;
        @(negedge clk);
        chk({tag, ".hold"},   64'(ready_o), 64'd1);
        start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({tag, ".drop"},   {62'd0, ready_o, busy_o}, 64'd0);
    endtask

    initial begin
        logic seen_rdy;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.res", result_o, 64'd0);
        chk("reset.flags", {60'd0, ready_o, busy_o, div_zero_o, stallreq_o}, 64'd0);
        rst = 1'b0;

        run_div("u100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14}, 1'b0);
        run_div("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_div("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0);
        run_div("s-8_-3",   1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 1'b0);
        run_div("u5_0",     1'b0, 32'd5,         32'd0,         64'd0, 1'b1);
        run_div("u9_3",     1'b0, 32'd9,         32'd3,         {32'd0, 32'd3}, 1'b0);
        run_div("smin_-1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        run_div("umin_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 1'b0);
        run_div("umax_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}, 1'b0);
        run_div("u0_9",     1'b0, 32'd0,         32'd9,         64'd0, 1'b0);
        run_div("u3_1",     1'b0, 32'd3,         32'd1,         {32'd0, 32'd3}, 1'b0);

        // start together with annul in IDLE is ignored
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        @(posedge clk); @(negedge clk);
        chk("start_annul.busy", 64'(busy_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;

        // annul at cycle 10: back to IDLE at cycle 11, result untouched
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
        seen_rdy = 1'b0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            seen_rdy = seen_rdy | ready_o;
        end
        start_i = 1'b0; annul_i = 1'b1;
        @(posedge clk); @(negedge clk);
        annul_i = 1'b0;
        chk("annul.busy", 64'(busy_o), 64'd0);
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            seen_rdy = seen_rdy | ready_o;
        end
        chk("annul.rdy", 64'(seen_rdy), 64'd0);
        chk("annul.res", result_o, {32'd0, 32'd3});

        run_div("u50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);

        // divide by zero, then reset in the middle of a normal divide
        run_div("u7_0", 1'b0, 32'd7, 32'd0, 64'd0, 1'b1);
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'hFFFF_0000; opdata2_i = 32'd3;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        chk("mid.busy", 64'(busy_o), 64'd1);
        start_i = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_mid.res", result_o, 64'd0);
        chk("rst_mid.flags", {60'd0, ready_o, busy_o, div_zero_o, stallreq_o}, 64'd0);
        rst = 1'b0;

        run_div("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
